// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
// The owner-id width helper keeps pointer widths legal for any requester count.
package ram_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRdWait
    } arb_state_e;

    localparam int unsigned DefNumReq = 2;
    localparam int unsigned DefAddrW  = 6;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefDepth  = 32;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// addr_err exists only when RAM_ADDR_CHECK_EN is defined.
interface ram_port_arbiter_if #(
    parameter int unsigned NUM_REQ = ram_arb_pkg::DefNumReq,
    parameter int unsigned ADDR_W  = ram_arb_pkg::DefAddrW,
    parameter int unsigned DATA_W  = ram_arb_pkg::DefDataW
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      ram_en;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_data;
    logic [DATA_W-1:0]         ram_q;
`ifdef RAM_ADDR_CHECK_EN
    logic                      addr_err;
`endif

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_q,
`ifdef RAM_ADDR_CHECK_EN
        output addr_err,
`endif
        output req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_q,
`ifdef RAM_ADDR_CHECK_EN
        input  addr_err,
`endif
        input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans from the last winner + 1 with wrap-around.
// The pointer moves only when a grant is actually issued.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               grant_en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [IdW-1:0] last_q, last_d;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        last_d      = last_q;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_q) + off) % NUM_REQ;
            if (grant_en_i && !gnt_valid_o && req_i[idx]) begin
                gnt_o[idx]  = 1'b1;
                gnt_valid_o = 1'b1;
                last_d      = IdW'(idx);
            end
        end
    end

    // Reset to the highest id so the first scan starts at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IdW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one registered-address single-port RAM between NUM_REQ requesters.
// Optional out-of-range address filtering under RAM_ADDR_CHECK_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned DEPTH   = DefDepth
) (
    input logic                clk,
    input logic                rst,
    ram_port_arbiter_if.slave  bus
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               oob_q, oob_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic               win_we;
    logic               win_oob;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.req_valid),
        .grant_en_i  ((state_q == StIdle) && !rst),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_we    = bus.req_we[i];
                win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RAM_ADDR_CHECK_EN
    assign win_oob = (32'(win_addr) >= DEPTH);
`else
    assign win_oob = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        oob_d        = oob_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        bus.req_ready = '0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_data  = '0;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    bus.req_ready = gnt;
                    bus.ram_en    = !win_oob;
                    bus.ram_we    = win_we && !win_oob;
                    bus.ram_addr  = win_addr;
                    bus.ram_data  = win_wdata;
                    if (!win_we) begin
                        state_d = StRdWait;
                        owner_d = gnt;
                        addr_d  = win_addr;
                        oob_d   = win_oob;
                    end
                end
            end
            StRdWait: begin
                // Hold the address so the RAM sees a stable read for its capture edge.
                bus.ram_en   = !oob_q;
                bus.ram_addr = addr_q;
                rsp_valid_d  = owner_q;
                rsp_rdata_d  = oob_q ? '0 : bus.ram_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            addr_q      <= '0;
            oob_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            oob_q       <= oob_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef RAM_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = (state_q == StRdWait) && oob_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-address RAM.
// Three requesters so that twelve rotating reads give four responses each.
module tb_ram_port_arbiter;

    localparam int unsigned NR    = 3;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [64];
    logic [DW-1:0] ram_q_q;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
            else            ram_q_q <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_q = ram_q_q;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int unsigned id, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[id]          = v;
        bus.req_we[id]             = we;
        bus.req_addr[id*AW +: AW]  = a;
        bus.req_wdata[id*DW +: DW] = d;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write_req(input int unsigned id, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic exp_en);
        set_req(id, 1'b1, 1'b1, a, d);
        #1;
        check_eq("wr_ready", 32'(bus.req_ready), 32'(1) << id);
        check_eq("wr_ram_en", 32'(bus.ram_en), 32'(exp_en));
        check_eq("wr_ram_we", 32'(bus.ram_we), 32'(exp_en));
        if (exp_en) begin
            check_eq("wr_ram_addr", 32'(bus.ram_addr), 32'(a));
            check_eq("wr_ram_data", 32'(bus.ram_data), 32'(d));
        end
        step();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic read_req(input int unsigned id, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp_d, input logic exp_en,
                            input logic exp_err);
        set_req(id, 1'b1, 1'b0, a, '0);
        #1;
        check_eq("rd_ready", 32'(bus.req_ready), 32'(1) << id);
        check_eq("rd_ram_en", 32'(bus.ram_en), 32'(exp_en));
        check_eq("rd_ram_we", 32'(bus.ram_we), 32'(0));
        if (exp_en) check_eq("rd_ram_addr", 32'(bus.ram_addr), 32'(a));
        step();
        bus.req_valid[id] = 1'b0;
        #1;
        check_eq("rdwait_ready", 32'(bus.req_ready), 32'(0));
        check_eq("rdwait_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check_eq("rdwait_ram_en", 32'(bus.ram_en), 32'(exp_en));
        if (exp_en) check_eq("rdwait_ram_addr", 32'(bus.ram_addr), 32'(a));
        step();
        #1;
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(1) << id);
        check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_d));
`ifdef RAM_ADDR_CHECK_EN
        check_eq("addr_err", 32'(bus.addr_err), 32'(exp_err));
`else
        if (exp_err) check_eq("addr_err_unexpected", 32'(exp_err), 32'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_data [NR];
        int            cnt [NR];
        logic [31:0]   exp_rdy;
        int unsigned   id;

        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state.
        do_reset();
        #1;
        check_eq("rst_ready", 32'(bus.req_ready), 32'(0));
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
        check_eq("rst_ram_en", 32'(bus.ram_en), 32'(0));
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'(0));
`ifdef RAM_ADDR_CHECK_EN
        check_eq("rst_addr_err", 32'(bus.addr_err), 32'(0));
`endif

        // Single write then single read.
        write_req(0, 6'd3, 8'hA5, 1'b1);
        read_req(0, 6'd3, 8'hA5, 1'b1, 1'b0);
        step();

        // Contention from reset: r0 then r1 on consecutive cycles.
        do_reset();
        set_req(0, 1'b1, 1'b1, 6'd1, 8'h11);
        set_req(1, 1'b1, 1'b1, 6'd2, 8'h22);
        #1;
        check_eq("cont_ready0", 32'(bus.req_ready), 32'h1);
        check_eq("cont_addr0", 32'(bus.ram_addr), 32'd1);
        check_eq("cont_data0", 32'(bus.ram_data), 32'h11);
        step();
        bus.req_valid[0] = 1'b0;
        #1;
        check_eq("cont_ready1", 32'(bus.req_ready), 32'h2);
        check_eq("cont_addr1", 32'(bus.ram_addr), 32'd2);
        check_eq("cont_data1", 32'(bus.ram_data), 32'h22);
        step();
        bus.req_valid[1] = 1'b0;
        read_req(0, 6'd1, 8'h11, 1'b1, 1'b0);
        read_req(1, 6'd2, 8'h22, 1'b1, 1'b0);
        step();

        // Fairness: three requesters reading continuously.
        exp_data[0] = 8'h11;
        exp_data[1] = 8'h22;
        exp_data[2] = 8'hA5;
        for (int j = 0; j < int'(NR); j++) cnt[j] = 0;
        do_reset();
        set_req(0, 1'b1, 1'b0, 6'd1, '0);
        set_req(1, 1'b1, 1'b0, 6'd2, '0);
        set_req(2, 1'b1, 1'b0, 6'd3, '0);
        for (int k = 0; k <= 24; k++) begin
            if (k == 24) bus.req_valid = '0;
            #1;
            exp_rdy = (k % 2 == 0 && k < 24) ? (32'(1) << ((k / 2) % 3)) : 32'(0);
            check_eq("fair_ready", 32'(bus.req_ready), exp_rdy);
            if (k >= 2 && k % 2 == 0) begin
                id = 32'(((k - 2) / 2) % 3);
                check_eq("fair_rsp_valid", 32'(bus.rsp_valid), 32'(1) << id);
                check_eq("fair_rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_data[id]));
            end else begin
                check_eq("fair_rsp_idle", 32'(bus.rsp_valid), 32'(0));
            end
            for (int j = 0; j < int'(NR); j++) if (bus.rsp_valid[j]) cnt[j]++;
            step();
        end
        for (int j = 0; j < int'(NR); j++) check_eq("fair_count", 32'(cnt[j]), 32'd4);

        // Reset while a read is in RD_WAIT.
        do_reset();
        set_req(2, 1'b1, 1'b0, 6'd2, '0);
        #1;
        check_eq("rstrd_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("rstrd_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check_eq("rstrd_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
        check_eq("rstrd_ram_en", 32'(bus.ram_en), 32'(0));
        check_eq("rstrd_ram_addr", 32'(bus.ram_addr), 32'(0));
        check_eq("rstrd_ready_idle", 32'(bus.req_ready), 32'(0));
        set_req(0, 1'b1, 1'b0, 6'd1, '0);
        set_req(2, 1'b1, 1'b0, 6'd2, '0);
        #1;
        check_eq("rstrd_next_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        #1;
        check_eq("rstrd_no_early_rsp", 32'(bus.rsp_valid), 32'(0));
        step();
        #1;
        check_eq("rstrd_rsp", 32'(bus.rsp_valid), 32'h1);
        check_eq("rstrd_rdata", 32'(bus.rsp_rdata), 32'h11);
        step();

        // Last implemented word behaves normally.
        write_req(1, 6'd31, 8'h5A, 1'b1);
        read_req(1, 6'd31, 8'h5A, 1'b1, 1'b0);
        step();

`ifdef RAM_ADDR_CHECK_EN
        // Out-of-range: handshaken but the RAM is never enabled.
        write_req(2, 6'd40, 8'h77, 1'b0);
        read_req(2, 6'd40, 8'h00, 1'b0, 1'b1);
        step();
        #1;
        check_eq("addr_err_clear", 32'(bus.addr_err), 32'(0));
        check_eq("oob_ram_untouched", 32'(mem[31]), 32'h5A);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
